token_rx_assembler: RTL and testbench
=====================================

TOKEN_RX_ASSEMBLER -- requirements
Module: token_rx_assembler

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16; max idle cycles allowed between bytes inside a packet.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port rx_active  input  1  high while the receiver is inside a packet, from SYNC to EOP.
REQ-005 SHALL have port rx_valid  input  1  qualifies rx_byte for one cycle.
REQ-006 SHALL have port rx_byte  input  8  received byte, bit 0 first on the wire.
REQ-007 SHALL have port rx_eop  input  1  one-cycle end-of-packet strobe.
REQ-008 SHALL have port token_data  output  24  {PID byte, byte1, byte2} for the downstream token decoder; holds its value until the next token.
REQ-009 SHALL have port token_valid  output  1  one-cycle pulse when token_data is new and complete.
REQ-010 SHALL have port token_err  output  1  one-cycle pulse on an aborted or malformed packet.
REQ-011 SHALL have port busy  output  1  high when the FSM is not in IDLE.

Function
REQ-012 FSM states SHALL be IDLE, PID, BYTE1, BYTE2, WAIT_EOP.
REQ-013 IDLE->PID SHALL occur on rx_active rising, detected from a registered copy.
REQ-014 In PID, an rx_valid byte SHALL be captured.
- If rx_byte[7:4] == ~rx_byte[3:0] and rx_byte[1:0] == 2'b01 (token class: OUT 0xE1, IN 0x69, SOF 0xA5, SETUP 0x2D), the FSM SHALL go to BYTE1.
- Otherwise it SHALL go to WAIT_EOP with the error flag set.
REQ-015 BYTE1 SHALL capture rx_byte into token bits [15:8]; BYTE2 SHALL capture it into bits [7:0] and then go to WAIT_EOP.
REQ-016 WAIT_EOP on rx_eop, with no error and exactly 3 bytes received:
- token_data SHALL update with the three bytes in the same edge.
- token_valid SHALL pulse for 1 cycle.
- The FSM SHALL return to IDLE.
REQ-017 WAIT_EOP with error set, or a 4th rx_valid byte: token_err SHALL pulse on rx_eop, token_data SHALL be unchanged, and the FSM SHALL return to IDLE.
REQ-018 rx_eop in PID, BYTE1 or BYTE2 (short packet) SHALL pulse token_err and return the FSM to IDLE.
REQ-019 An idle counter (width clog2(TIMEOUT+1)) SHALL clear on every rx_valid and on every state change.
- It SHALL increment each cycle in PID, BYTE1, BYTE2 and WAIT_EOP.
- On reaching TIMEOUT it SHALL pulse token_err and force IDLE.
- It SHALL saturate and never wrap.
REQ-020 rx_active falling without rx_eop outside IDLE SHALL be treated as rx_eop.
REQ-021 rx_valid and rx_eop in the same cycle: the byte SHALL be processed first, then the EOP rules SHALL be evaluated on the updated byte count.
REQ-022 token_valid and token_err SHALL never be high in the same cycle.
REQ-023 Latency SHALL be 1 cycle from rx_eop to token_valid/token_err.
REQ-024 rx_valid in IDLE SHALL be ignored.

Reset
REQ-025 While reset is high, outputs SHALL be: token_data=24'h000000, token_valid=0, token_err=0, busy=0.
REQ-026 While reset is high, the FSM SHALL be in IDLE and the idle counter and byte count SHALL be 0.
REQ-027 Reset asserted mid-packet SHALL discard the partial packet with no pulse.
REQ-028 After reset release, the first packet SHALL be accepted only on a new rx_active rising edge.

Verification
REQ-029 IN token: bytes 0x69, 0x81, 0x58 then rx_eop -> token_data=24'h698158, token_valid pulses once, token_err=0.
REQ-030 Bad PID 0x68 then 2 bytes then rx_eop -> token_err pulse, token_data holds its previous value.
REQ-031 Short packet, PID 0xE1 and 1 byte then rx_eop -> token_err pulse, FSM in IDLE, busy=0 the next cycle.
REQ-032 4-byte packet 0x2D, 0x00, 0x10, 0xFF then rx_eop -> token_err pulse, no token_valid.
REQ-033 Timeout: PID 0xA5, then no bytes for TIMEOUT cycles -> token_err pulse at count TIMEOUT; a following valid packet is decoded correctly.
REQ-034 Reset pulsed after BYTE1 -> outputs at reset values, no pulse; the next full token is decoded normally.

Source files
------------

// File: rtl/token_rx_assembler.sv
// ============================================================================
// Module   : token_rx_assembler
// Brief    : Collects PID + two bytes from a byte receiver into a 24-bit token.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module token_rx_assembler #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_active,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  input  logic        rx_eop,
  output logic [23:0] token_data,
  output logic        token_valid,
  output logic        token_err,
  output logic        busy
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] C_TIMEOUT = CW'(TIMEOUT);
  localparam logic [CW-1:0] C_ONE     = CW'(1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PID      = 3'd1;
  localparam logic [2:0] S_BYTE1    = 3'd2;
  localparam logic [2:0] S_BYTE2    = 3'd3;
  localparam logic [2:0] S_WAIT_EOP = 3'd4;

  logic [2:0]    r_state, w_state_n;
  logic          r_active_q;
  logic [CW-1:0] r_idle_cnt;
  logic [2:0]    r_byte_cnt, w_byte_cnt_n;
  logic          r_err, w_err_n;
  logic [7:0]    r_pid, r_b1, r_b2;
  logic [7:0]    w_pid_n, w_b1_n, w_b2_n;
  logic          w_accept, w_reject;
  logic          w_rise, w_fall, w_eop_evt, w_pid_ok;

  assign w_rise    = rx_active & ~r_active_q;
  assign w_fall    = ~rx_active & r_active_q;
  assign w_eop_evt = rx_eop | w_fall;
  assign w_pid_ok  = (rx_byte[7:4] == ~rx_byte[3:0]) && (rx_byte[1:0] == 2'b01);

  // State register and datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      // Reset high so a receiver already mid-packet at release is not seen as a new start
      r_active_q  <= 1'b1;
      r_idle_cnt  <= '0;
      r_byte_cnt  <= '0;
      r_err       <= 1'b0;
      r_pid       <= '0;
      r_b1        <= '0;
      r_b2        <= '0;
      token_data  <= '0;
      token_valid <= 1'b0;
      token_err   <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_active_q  <= rx_active;
      r_byte_cnt  <= w_byte_cnt_n;
      r_err       <= w_err_n;
      r_pid       <= w_pid_n;
      r_b1        <= w_b1_n;
      r_b2        <= w_b2_n;
      token_valid <= w_accept;
      token_err   <= w_reject;
      if (w_accept)
        token_data <= {w_pid_n, w_b1_n, w_b2_n};
      if (rx_valid || (w_state_n != r_state))
        r_idle_cnt <= '0;
      else if ((r_state != S_IDLE) && (r_idle_cnt < C_TIMEOUT))
        r_idle_cnt <= r_idle_cnt + C_ONE;
    end
  end

  // Next-state: the byte is applied first, then EOP rules see the updated count
  always_comb begin
    w_state_n    = r_state;
    w_byte_cnt_n = r_byte_cnt;
    w_err_n      = r_err;
    w_pid_n      = r_pid;
    w_b1_n       = r_b1;
    w_b2_n       = r_b2;
    w_accept     = 1'b0;
    w_reject     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_state_n    = S_PID;
          w_byte_cnt_n = '0;
          w_err_n      = 1'b0;
        end
      end
      S_PID: begin
        if (rx_valid) begin
          w_pid_n      = rx_byte;
          w_byte_cnt_n = 3'd1;
          if (w_pid_ok) begin
            w_state_n = S_BYTE1;
          end else begin
            w_state_n = S_WAIT_EOP;
            w_err_n   = 1'b1;
          end
        end
      end
      S_BYTE1: begin
        if (rx_valid) begin
          w_b1_n       = rx_byte;
          w_byte_cnt_n = 3'd2;
          w_state_n    = S_BYTE2;
        end
      end
      S_BYTE2: begin
        if (rx_valid) begin
          w_b2_n       = rx_byte;
          w_byte_cnt_n = 3'd3;
          w_state_n    = S_WAIT_EOP;
        end
      end
      S_WAIT_EOP: begin
        if (rx_valid) begin
          w_byte_cnt_n = (r_byte_cnt == 3'd4) ? 3'd4 : r_byte_cnt + 3'd1;
          w_err_n      = 1'b1;
        end
      end
      default: w_state_n = S_IDLE;
    endcase

    if (r_state != S_IDLE) begin
      if (w_eop_evt) begin
        w_state_n = S_IDLE;
        if (!w_err_n && (w_byte_cnt_n == 3'd3))
          w_accept = 1'b1;
        else
          w_reject = 1'b1;
      end else if (!rx_valid && (r_idle_cnt == C_TIMEOUT)) begin
        w_state_n = S_IDLE;
        w_reject  = 1'b1;
      end
    end
  end

  // Outputs
  always_comb begin
    busy = (r_state != S_IDLE);
  end

endmodule

`default_nettype wire

// File: tb/tb_token_rx_assembler.sv
// ============================================================================
// Module   : tb_token_rx_assembler
// Brief    : Directed self-checking bench for token_rx_assembler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_token_rx_assembler;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_active;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        rx_eop;
  logic [23:0] token_data;
  logic        token_valid;
  logic        token_err;
  logic        busy;

  int tests_run = 0;
  int tests_failed = 0;

  token_rx_assembler #(.TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_active  (rx_active),
    .rx_valid   (rx_valid),
    .rx_byte    (rx_byte),
    .rx_eop     (rx_eop),
    .token_data (token_data),
    .token_valid(token_valid),
    .token_err  (token_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pkt_begin();
    rx_active = 1'b1;
    step();
  endtask

  // bytes are taken MSB-first from the packed word
  task automatic send_bytes(input logic [31:0] bytes, input int n);
    for (int i = 0; i < n; i++) begin
      rx_valid = 1'b1;
      rx_byte  = bytes[31 - 8*i -: 8];
      step();
    end
    rx_valid = 1'b0;
  endtask

  // Ends the packet; on return the result pulse is visible
  task automatic pkt_end(input bit use_eop);
    rx_eop    = use_eop;
    rx_active = 1'b0;
    step();
    rx_eop    = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    rx_active = 1'b0;
    rx_valid  = 1'b0;
    rx_byte   = 8'h00;
    rx_eop    = 1'b0;
    step();
    step();
    chk("rst_data",  {8'h0, token_data}, 32'h0);
    chk("rst_valid", {31'h0, token_valid}, 32'h0);
    chk("rst_err",   {31'h0, token_err}, 32'h0);
    chk("rst_busy",  {31'h0, busy}, 32'h0);
    reset = 1'b0;
    step();

    // A byte while idle is ignored
    rx_valid = 1'b1; rx_byte = 8'h69;
    step();
    rx_valid = 1'b0;
    chk("idle_byte_busy", {31'h0, busy}, 32'h0);

    // IN token
    pkt_begin();
    chk("in_busy", {31'h0, busy}, 32'h1);
    send_bytes(32'h69815800, 3);
    pkt_end(1'b1);
    chk("in_valid", {31'h0, token_valid}, 32'h1);
    chk("in_err",   {31'h0, token_err}, 32'h0);
    chk("in_data",  {8'h0, token_data}, 32'h00698158);
    step();
    chk("in_valid_1cyc", {31'h0, token_valid}, 32'h0);
    chk("in_idle", {31'h0, busy}, 32'h0);

    // Bad PID
    pkt_begin();
    send_bytes(32'h68112200, 3);
    pkt_end(1'b1);
    chk("badpid_err",   {31'h0, token_err}, 32'h1);
    chk("badpid_valid", {31'h0, token_valid}, 32'h0);
    chk("badpid_data",  {8'h0, token_data}, 32'h00698158);
    step();
    chk("badpid_err_1cyc", {31'h0, token_err}, 32'h0);

    // Short packet
    pkt_begin();
    send_bytes(32'hE1810000, 2);
    pkt_end(1'b1);
    chk("short_err", {31'h0, token_err}, 32'h1);
    step();
    chk("short_busy", {31'h0, busy}, 32'h0);
    chk("short_err_1cyc", {31'h0, token_err}, 32'h0);

    // Four-byte packet
    pkt_begin();
    send_bytes(32'h2D0010FF, 4);
    pkt_end(1'b1);
    chk("long_err",   {31'h0, token_err}, 32'h1);
    chk("long_valid", {31'h0, token_valid}, 32'h0);
    chk("long_data",  {8'h0, token_data}, 32'h00698158);
    step();

    // Timeout after PID: counter reaches TIMEOUT, error follows on the next edge
    pkt_begin();
    send_bytes(32'hA5000000, 1);
    for (int i = 0; i < TIMEOUT; i++) step();
    chk("to_not_yet_err",  {31'h0, token_err}, 32'h0);
    chk("to_not_yet_busy", {31'h0, busy}, 32'h1);
    step();
    chk("to_err",  {31'h0, token_err}, 32'h1);
    chk("to_busy", {31'h0, busy}, 32'h0);
    rx_active = 1'b0;
    step();
    chk("to_err_1cyc", {31'h0, token_err}, 32'h0);
    pkt_begin();
    send_bytes(32'hA53F7A00, 3);
    pkt_end(1'b1);
    chk("to_next_valid", {31'h0, token_valid}, 32'h1);
    chk("to_next_data",  {8'h0, token_data}, 32'h00A53F7A);
    step();

    // Last byte and EOP together
    pkt_begin();
    send_bytes(32'hE15A0000, 2);
    rx_valid = 1'b1; rx_byte = 8'hC3; rx_eop = 1'b1; rx_active = 1'b0;
    step();
    rx_valid = 1'b0; rx_eop = 1'b0;
    chk("same_valid", {31'h0, token_valid}, 32'h1);
    chk("same_err",   {31'h0, token_err}, 32'h0);
    chk("same_data",  {8'h0, token_data}, 32'h00E15AC3);
    step();

    // rx_active dropping without EOP ends the packet
    pkt_begin();
    send_bytes(32'h2D123400, 3);
    pkt_end(1'b0);
    chk("fall_valid", {31'h0, token_valid}, 32'h1);
    chk("fall_data",  {8'h0, token_data}, 32'h002D1234);
    step();

    // Reset in the middle of a packet
    pkt_begin();
    send_bytes(32'h2D110000, 2);
    reset = 1'b1;
    step();
    chk("midrst_data",  {8'h0, token_data}, 32'h0);
    chk("midrst_valid", {31'h0, token_valid}, 32'h0);
    chk("midrst_err",   {31'h0, token_err}, 32'h0);
    chk("midrst_busy",  {31'h0, busy}, 32'h0);
    reset = 1'b0;
    step();
    step();
    chk("midrst_no_restart", {31'h0, busy}, 32'h0);
    rx_active = 1'b0;
    step();
    chk("midrst_no_pulse", {30'h0, token_valid, token_err}, 32'h0);
    pkt_begin();
    send_bytes(32'h69010200, 3);
    pkt_end(1'b1);
    chk("midrst_next_valid", {31'h0, token_valid}, 32'h1);
    chk("midrst_next_data",  {8'h0, token_data}, 32'h00690102);
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
